// File: rtl/vga_cmd_pkg.sv
// Shared types and constants for the VGA command engine: FSM states,
// command register addresses and the coordinate-width helper.
package vga_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PIXEL,
        ST_CLEAR,
        ST_RECT_SETUP,
        ST_RECT
    } state_t;

    localparam logic [31:0] CMD_CLEAR     = 32'h000;
    localparam logic [31:0] CMD_RECT_ORG  = 32'h004;
    localparam logic [31:0] CMD_RECT_SIZE = 32'h008;
    localparam logic [31:0] CMD_RECT_FILL = 32'h00C;

    // Bits needed to hold any coordinate up to and including the resolution itself.
    function automatic int coord_w(input int h_res, input int v_res);
        int m;
        m = (h_res > v_res) ? h_res : v_res;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/vga_rect_walker.sv
// Raster walker: steps x/y across a rectangle and tracks the row base
// address incrementally, so no multiplier sits in the per-pixel loop.
module vga_rect_walker #(
    parameter int P_H_RES  = 640,
    parameter int P_ADDR_W = 19,
    parameter int P_CW     = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                advance,
    input  logic [P_CW-1:0]     x_origin,
    input  logic [P_CW-1:0]     y_origin,
    input  logic [P_CW-1:0]     x_limit,
    input  logic [P_CW-1:0]     y_limit,
    input  logic [P_ADDR_W-1:0] row_base_init,
    output logic [P_ADDR_W-1:0] addr,
    output logic                last
);

    localparam logic [P_ADDR_W-1:0] H_STEP = P_ADDR_W'(P_H_RES);

    logic [P_CW-1:0]     x, y, x0_q, x_lim_q, y_lim_q;
    logic [P_ADDR_W-1:0] row_base;
    logic                row_end;

    assign row_end = (x == x_lim_q - P_CW'(1));
    assign last    = row_end && (y == y_lim_q - P_CW'(1));
    assign addr    = row_base + P_ADDR_W'(x);

    always_ff @(posedge clk) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            x0_q     <= '0;
            x_lim_q  <= '0;
            y_lim_q  <= '0;
            row_base <= '0;
        end else if (start) begin
            x        <= x_origin;
            y        <= y_origin;
            x0_q     <= x_origin;
            x_lim_q  <= x_limit;
            y_lim_q  <= y_limit;
            row_base <= row_base_init;
        end else if (advance) begin
            if (row_end) begin
                x        <= x0_q;
                y        <= y + P_CW'(1);
                row_base <= row_base + H_STEP;
            end else begin
                x <= x + P_CW'(1);
            end
        end
    end

endmodule

// File: rtl/vga_command_engine.sv
// Bus command front end for VRAM: single pixel writes, full-screen clear
// and clipped rectangle fill, one pixel write per unstalled cycle.
module vga_command_engine #(
    parameter int          P_H_RES       = 640,
    parameter int          P_V_RES       = 480,
    parameter int          P_ADDR_W      = 19,
    parameter int          P_DATA_W      = 16,
    parameter logic [31:0] P_BITMAP_BASE = 32'h100
) (
    input  logic                iCLOCK,
    input  logic                iRESET_SYNC,
    input  logic                iBUSMOD_REQ,
    input  logic [31:0]         iBUSMOD_ADDR,
    input  logic [31:0]         iBUSMOD_DATA,
    output logic                oBUSMOD_WAIT,
    output logic                oCMD_DONE,
    input  logic                iVRAM_WAIT,
    output logic                oVRAM_WRITE_REQ,
    output logic [P_ADDR_W-1:0] oVRAM_WRITE_ADDR,
    output logic [P_DATA_W-1:0] oVRAM_WRITE_DATA
);
    import vga_cmd_pkg::*;

    localparam int                  CW     = coord_w(P_H_RES, P_V_RES);
    localparam int                  NPIX   = P_H_RES * P_V_RES;
    localparam logic [32:0]         BMP_LO = {1'b0, P_BITMAP_BASE};
    localparam logic [32:0]         BMP_HI = BMP_LO + 33'(NPIX);
    localparam logic [P_ADDR_W-1:0] H_STEP = P_ADDR_W'(P_H_RES);

    state_t              state, state_next;
    logic                accept, is_bitmap, write_go, rect_empty;
    logic                walk_start, walk_advance, walk_last;
    logic [15:0]         rect_x0, rect_y0, rect_w, rect_h;
    logic [16:0]         x_sum, y_sum;
    logic [CW-1:0]       x_end, y_end;
    logic [CW-1:0]       walk_x0, walk_y0, walk_xl, walk_yl;
    logic [P_ADDR_W-1:0] walk_row, walk_addr, pixel_addr;
    logic [P_DATA_W-1:0] colour;

    assign oBUSMOD_WAIT     = iVRAM_WAIT || (state != ST_IDLE);
    assign accept           = iBUSMOD_REQ && !oBUSMOD_WAIT;
    assign is_bitmap        = ({1'b0, iBUSMOD_ADDR} >= BMP_LO) && ({1'b0, iBUSMOD_ADDR} < BMP_HI);
    assign write_go         = oVRAM_WRITE_REQ;
    assign oVRAM_WRITE_DATA = colour;

    // Clipping is done in 17 bits so origin+size cannot wrap before the min().
    assign rect_empty = (rect_x0 >= 16'(P_H_RES)) || (rect_y0 >= 16'(P_V_RES))
                        || (rect_w == 16'd0) || (rect_h == 16'd0);
    assign x_sum = {1'b0, rect_x0} + {1'b0, rect_w};
    assign y_sum = {1'b0, rect_y0} + {1'b0, rect_h};
    assign x_end = (x_sum > 17'(P_H_RES)) ? CW'(P_H_RES) : x_sum[CW-1:0];
    assign y_end = (y_sum > 17'(P_V_RES)) ? CW'(P_V_RES) : y_sum[CW-1:0];

    always_comb begin
        if (state == ST_RECT_SETUP) begin
            walk_x0  = rect_x0[CW-1:0];
            walk_y0  = rect_y0[CW-1:0];
            walk_xl  = x_end;
            walk_yl  = y_end;
            walk_row = P_ADDR_W'(rect_y0[CW-1:0]) * H_STEP;
        end else begin
            walk_x0  = '0;
            walk_y0  = '0;
            walk_xl  = CW'(P_H_RES);
            walk_yl  = CW'(P_V_RES);
            walk_row = '0;
        end
    end

    assign walk_start   = (accept && (iBUSMOD_ADDR == CMD_CLEAR))
                          || ((state == ST_RECT_SETUP) && !rect_empty);
    assign walk_advance = write_go && ((state == ST_CLEAR) || (state == ST_RECT));

    vga_rect_walker #(
        .P_H_RES  (P_H_RES),
        .P_ADDR_W (P_ADDR_W),
        .P_CW     (CW)
    ) u_walker (
        .clk           (iCLOCK),
        .rst           (iRESET_SYNC),
        .start         (walk_start),
        .advance       (walk_advance),
        .x_origin      (walk_x0),
        .y_origin      (walk_y0),
        .x_limit       (walk_xl),
        .y_limit       (walk_yl),
        .row_base_init (walk_row),
        .addr          (walk_addr),
        .last          (walk_last)
    );

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            rect_x0    <= '0;
            rect_y0    <= '0;
            rect_w     <= '0;
            rect_h     <= '0;
            colour     <= '0;
            pixel_addr <= '0;
        end else if (accept) begin
            if (iBUSMOD_ADDR == CMD_RECT_ORG) begin
                rect_x0 <= iBUSMOD_DATA[15:0];
                rect_y0 <= iBUSMOD_DATA[31:16];
            end else if (iBUSMOD_ADDR == CMD_RECT_SIZE) begin
                rect_w <= iBUSMOD_DATA[15:0];
                rect_h <= iBUSMOD_DATA[31:16];
            end else if ((iBUSMOD_ADDR == CMD_CLEAR) || (iBUSMOD_ADDR == CMD_RECT_FILL)) begin
                colour <= iBUSMOD_DATA[P_DATA_W-1:0];
            end else if (is_bitmap) begin
                colour     <= iBUSMOD_DATA[P_DATA_W-1:0];
                pixel_addr <= P_ADDR_W'(iBUSMOD_ADDR - P_BITMAP_BASE);
            end
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) state <= ST_IDLE;
        else             state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (iBUSMOD_ADDR == CMD_CLEAR)          state_next = ST_CLEAR;
                    else if (iBUSMOD_ADDR == CMD_RECT_FILL) state_next = ST_RECT_SETUP;
                    else if (is_bitmap)                     state_next = ST_PIXEL;
                end
            end
            ST_PIXEL:      if (write_go) state_next = ST_IDLE;
            ST_CLEAR,
            ST_RECT:       if (write_go && walk_last) state_next = ST_IDLE;
            ST_RECT_SETUP: state_next = rect_empty ? ST_IDLE : ST_RECT;
            default:       state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        oVRAM_WRITE_REQ  = 1'b0;
        oCMD_DONE        = 1'b0;
        oVRAM_WRITE_ADDR = walk_addr;
        case (state)
            ST_PIXEL: begin
                oVRAM_WRITE_REQ  = !iVRAM_WAIT;
                oVRAM_WRITE_ADDR = pixel_addr;
            end
            ST_CLEAR,
            ST_RECT: begin
                oVRAM_WRITE_REQ = !iVRAM_WAIT;
                oCMD_DONE       = !iVRAM_WAIT && walk_last;
            end
            ST_RECT_SETUP: oCMD_DONE = rect_empty;
            default: ;
        endcase
    end

endmodule
